serv_decode_queue: RTL and testbench
====================================

Name: serv_decode_queue

Overview:
- Parametrised successor to the single-entry SERV instruction decoder.
- Buffers up to DEPTH fetched instruction words, predecoded on enqueue, so fetch can run ahead of the bit-serial core.
- Presents the predecoded bundle of the oldest entry to the state/ctrl logic.
- Adds valid/ready handshaking, flush on redirect, illegal-instruction detection and optional MDU decode.
- Sits between the ibus wishbone return path and the core control logic.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- MDU, 0, 1 enables decode of M-extension OP instructions (funct7[0]=1).
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_wb_rdt  input  32  fetched instruction word
- i_wb_valid  input  1  fetched word valid
- o_wb_ready  output  1  queue can accept a word (not full)
- i_flush  input  1  discard all entries (branch/trap redirect)
- i_ack  input  1  core consumed head entry
- o_valid  output  1  head entry present
- o_count  output  AW+1  number of valid entries
- o_opcode  output  5  head instr[6:2]
- o_funct3  output  3  head instr[14:12]
- o_rd_addr  output  5  head instr[11:7]
- o_rs1_addr  output  5  head instr[19:15]
- o_rs2_addr  output  5  head instr[24:20]
- o_imm30  output  1  head instr[30]
- o_rd_op  output  1  head writes rd
- o_mdu_op  output  1  head is an MDU op
- o_illegal  output  1  head is an unsupported encoding

Behaviour:
- Reset (async assert, sync release): count=0, read/write pointers=0, o_valid=0, o_wb_ready=1. Bundle outputs are 0 while o_valid=0 (gated).
- Push: i_wb_valid & o_wb_ready. The word is predecoded that cycle and the bundle is written to the entry at wptr. wptr wraps modulo DEPTH.
- Pop: i_ack & o_valid. rptr increments, wrapping modulo DEPTH. i_ack while empty is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, o_wb_ready=0, so push is blocked even if a pop occurs the same cycle (no combinational ready-from-ack path).
- Latency: a word pushed into an empty queue gives o_valid=1 on the next cycle. Head outputs are driven from storage only; there is no combinational path from i_wb_rdt to outputs.
- i_flush has priority over push and pop in the same cycle. Next cycle: count=0, wptr=rptr=0, and the same-cycle word is dropped.
- count: 0..DEPTH. o_wb_ready = (count != DEPTH). o_valid = (count != 0).
- Predecode equations:
  - rd_op = 1 for OP-IMM 00100, AUIPC 00101, OP 01100, LUI 01101, SYSTEM 11100, JALR 11001, JAL 11011, LOAD 00000; 0 otherwise.
  - mdu_op = MDU & opcode==01100 & instr[25].
  - illegal = instr[1:0]!=2'b11, or opcode not in {00000, 00011, 00100, 00101, 01000, 01100, 01101, 11000, 11001, 11011, 11100}, or (MDU=0 & opcode==01100 & instr[25]).
- An illegal entry still occupies a slot. rd_op is forced to 0 when illegal=1.
- Storage per entry: 5+3+5+5+5+1+3 = 27 bits. Memory needs no reset; pointers and count do.

Test Plan:
- Reset then push 0x00500093 (addi x1,x0,5) -> next cycle o_valid=1, o_opcode=00100, o_rd_addr=1, o_rs1_addr=0, o_rd_op=1, o_illegal=0, o_count=1.
- Push DEPTH=4 words without ack -> o_count=4, o_wb_ready=0; fifth i_wb_valid is not accepted. One ack -> o_count=3, o_wb_ready=1 the next cycle; the first word is popped in order.
- Fill to 2, then hold push+ack continuously for 10 cycles -> o_count stays 2, pointers wrap, heads appear in FIFO order.
- i_flush asserted with i_wb_valid=1 and count=3 -> next cycle o_count=0, o_valid=0, and the pushed word is absent on later refill.
- MDU=0: push 0x02208033 (mul) -> o_illegal=1, o_rd_op=0, o_mdu_op=0. With MDU=1: o_mdu_op=1, o_illegal=0, o_rd_op=1.
- Push 0x00000000 and 0x0000007F -> both o_illegal=1. Assert i_rst mid-stream with count=2 -> o_valid=0 and o_count=0 immediately (async).

Source files
------------

// File: rtl/serv_decode_queue.sv
// Multi-entry predecoding instruction queue between the ibus return path and SERV control.
// Fetched words are decoded on enqueue; the oldest entry's bundle is presented from storage.
module serv_decode_queue #(
    parameter int DEPTH = 4,
    parameter int MDU   = 0,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_valid,
    output logic          o_wb_ready,
    input  logic          i_flush,
    input  logic          i_ack,
    output logic          o_valid,
    output logic [AW:0]   o_count,
    output logic [4:0]    o_opcode,
    output logic [2:0]    o_funct3,
    output logic [4:0]    o_rd_addr,
    output logic [4:0]    o_rs1_addr,
    output logic [4:0]    o_rs2_addr,
    output logic          o_imm30,
    output logic          o_rd_op,
    output logic          o_mdu_op,
    output logic          o_illegal
);

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       imm30;
        logic       rd_op;
        logic       mdu_op;
        logic       illegal;
    } entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head;
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            push, pop;
    logic [4:0]      opc;
    logic            opc_ok, writes_rd, is_mext;
    logic            unused_bits;

    assign unused_bits = ^{i_wb_rdt[31], i_wb_rdt[29:26]};

    // Predecode of the incoming word
    assign opc     = i_wb_rdt[6:2];
    assign is_mext = (opc == 5'b01100) & i_wb_rdt[25];

    always_comb begin
        opc_ok = 1'b0;
        case (opc)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: opc_ok = 1'b1;
            default: opc_ok = 1'b0;
        endcase
    end

    always_comb begin
        writes_rd = 1'b0;
        case (opc)
            5'b00100, 5'b00101, 5'b01100, 5'b01101,
            5'b11100, 5'b11001, 5'b11011, 5'b00000: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.opcode  = opc;
        dec.funct3  = i_wb_rdt[14:12];
        dec.rd      = i_wb_rdt[11:7];
        dec.rs1     = i_wb_rdt[19:15];
        dec.rs2     = i_wb_rdt[24:20];
        dec.imm30   = i_wb_rdt[30];
        dec.illegal = (i_wb_rdt[1:0] != 2'b11) | ~opc_ok | ((MDU == 0) & is_mext);
        dec.mdu_op  = (MDU != 0) & is_mext;
        dec.rd_op   = writes_rd & ~dec.illegal;
    end

    // Ready depends only on registered count, never on i_ack
    assign o_wb_ready = (count != FULL);
    assign o_valid    = (count != '0);
    assign o_count    = count;
    assign push       = i_wb_valid & o_wb_ready;
    assign pop        = i_ack & o_valid;

    always_ff @(posedge clk) begin
        if (push && !i_flush)
            mem[wptr] <= dec;
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + ONE;
            else if (pop && !push) count <= count - ONE;
        end
    end

    // Bundle outputs read from storage and zeroed while empty
    assign head       = mem[rptr];
    assign o_opcode   = o_valid ? head.opcode  : '0;
    assign o_funct3   = o_valid ? head.funct3  : '0;
    assign o_rd_addr  = o_valid ? head.rd      : '0;
    assign o_rs1_addr = o_valid ? head.rs1     : '0;
    assign o_rs2_addr = o_valid ? head.rs2     : '0;
    assign o_imm30    = o_valid & head.imm30;
    assign o_rd_op    = o_valid & head.rd_op;
    assign o_mdu_op   = o_valid & head.mdu_op;
    assign o_illegal  = o_valid & head.illegal;

endmodule

// File: tb/tb_serv_decode_queue.sv
// Bench for serv_decode_queue: MDU=0 and MDU=1 instances driven together, checked
// against a queue-of-words reference model that decodes from the ISA rules.
module tb_serv_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_wb_rdt = '0;
    logic        i_wb_valid = 1'b0, i_flush = 1'b0, i_ack = 1'b0;

    logic       a_ready, a_valid, a_imm30, a_rd_op, a_mdu_op, a_illegal;
    logic [2:0] a_count, a_funct3;
    logic [4:0] a_opcode, a_rd, a_rs1, a_rs2;
    logic       m_ready, m_valid, m_imm30, m_rd_op, m_mdu_op, m_illegal;
    logic [2:0] m_count, m_funct3;
    logic [4:0] m_opcode, m_rd, m_rs1, m_rs2;

    serv_decode_queue #(.DEPTH(DEPTH), .MDU(0), .AW(2)) dut (
        .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_valid(i_wb_valid),
        .o_wb_ready(a_ready), .i_flush(i_flush), .i_ack(i_ack), .o_valid(a_valid),
        .o_count(a_count), .o_opcode(a_opcode), .o_funct3(a_funct3), .o_rd_addr(a_rd),
        .o_rs1_addr(a_rs1), .o_rs2_addr(a_rs2), .o_imm30(a_imm30), .o_rd_op(a_rd_op),
        .o_mdu_op(a_mdu_op), .o_illegal(a_illegal));

    serv_decode_queue #(.DEPTH(DEPTH), .MDU(1), .AW(2)) dut_m (
        .clk(clk), .i_rst(i_rst), .i_wb_rdt(i_wb_rdt), .i_wb_valid(i_wb_valid),
        .o_wb_ready(m_ready), .i_flush(i_flush), .i_ack(i_ack), .o_valid(m_valid),
        .o_count(m_count), .o_opcode(m_opcode), .o_funct3(m_funct3), .o_rd_addr(m_rd),
        .o_rs1_addr(m_rs1), .o_rs2_addr(m_rs2), .o_imm30(m_imm30), .o_rd_op(m_rd_op),
        .o_mdu_op(m_mdu_op), .o_illegal(m_illegal));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode: {opcode, funct3, rd, rs1, rs2, imm30, rd_op, mdu_op, illegal}
    function automatic logic [29:0] ref_dec(input logic [31:0] w, input bit mdu);
        logic [4:0] op;
        bit mext, ill, wr, md;
        op   = w[6:2];
        mext = (op == 5'b01100) && w[25];
        ill  = (w[1:0] != 2'b11) ||
               !(op inside {5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100}) ||
               (!mdu && mext);
        wr   = (op inside {5'b00100, 5'b00101, 5'b01100, 5'b01101,
                           5'b11100, 5'b11001, 5'b11011, 5'b00000}) && !ill;
        md   = mdu && mext;
        return {op, w[14:12], w[11:7], w[19:15], w[24:20], w[30], wr, md, ill};
    endfunction

    task automatic check_all();
        int n;
        n = q.size();
        chk("valid",   a_valid, n != 0);
        chk("count",   a_count, n);
        chk("ready",   a_ready, n != DEPTH);
        chk("count_m", m_count, n);
        chk("bundle",  {a_opcode, a_funct3, a_rd, a_rs1, a_rs2, a_imm30, a_rd_op, a_mdu_op, a_illegal},
                       n != 0 ? ref_dec(q[0], 0) : 30'd0);
        chk("bundle_m", {m_opcode, m_funct3, m_rd, m_rs1, m_rs2, m_imm30, m_rd_op, m_mdu_op, m_illegal},
                       n != 0 ? ref_dec(q[0], 1) : 30'd0);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check just after
    task automatic cycle(input bit v, input logic [31:0] w, input bit a, input bit f);
        bit do_push, do_pop;
        i_wb_valid = v; i_wb_rdt = w; i_ack = a; i_flush = f;
        @(posedge clk);
        do_push = v && (q.size() < DEPTH);
        do_pop  = a && (q.size() > 0);
        if (f) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(w);
        end
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1; k++)
            if (q.size() > 0) cycle(0, 32'h0, 1, 0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [4:0] ops [11];
        int sel;
        ops = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
        w   = $urandom;
        sel = $urandom_range(0, 13);
        w[6:2] = (sel < 11) ? ops[sel] : 5'($urandom);
        if ($urandom_range(0, 7) != 0) w[1:0] = 2'b11;
        return w;
    endfunction

    initial begin
        #1;
        check_all();
        @(posedge clk); @(posedge clk); #1;
        i_rst = 1'b0;
        check_all();

        // addi x1,x0,5 into empty queue
        cycle(1, 32'h0050_0093, 0, 0);
        chk("addi_opcode", a_opcode, 5'b00100);
        chk("addi_rd",     a_rd, 5'd1);
        chk("addi_rd_op",  a_rd_op, 1'b1);
        cycle(0, 32'h0, 1, 0);

        // Fill past full, then one ack
        for (int k = 0; k < 5; k++) cycle(1, 32'h0000_0013 | (32'(k + 1) << 7), 0, 0);
        chk("full_ready", a_ready, 1'b0);
        cycle(0, 32'h0, 1, 0);
        chk("after_ack_count", a_count, 3'd3);
        drain();

        // Steady push+pop at depth 2 with pointer wrap
        cycle(1, 32'h0010_0113, 0, 0);
        cycle(1, 32'h0020_0193, 0, 0);
        for (int k = 0; k < 10; k++) cycle(1, 32'h0000_0033 | (32'(k) << 15), 1, 0);
        chk("steady_count", a_count, 3'd2);
        drain();

        // Flush wins over same-cycle push
        for (int k = 0; k < 3; k++) cycle(1, 32'h0000_0013 | (32'(k) << 20), 0, 0);
        cycle(1, 32'h0AB0_0F93, 1, 1);
        chk("flush_count", a_count, 3'd0);
        cycle(1, 32'h0000_0237, 0, 0);
        chk("refill_opcode", a_opcode, 5'b01101);
        drain();

        // mul under both MDU settings
        cycle(1, 32'h0220_8033, 0, 0);
        chk("mul_illegal",   a_illegal, 1'b1);
        chk("mul_mdu_m",     m_mdu_op, 1'b1);
        chk("mul_rd_op_m",   m_rd_op, 1'b1);
        drain();

        // Compressed-looking and unknown-opcode words
        cycle(1, 32'h0000_0000, 0, 0);
        cycle(1, 32'h0000_007F, 0, 0);
        chk("zero_illegal", a_illegal, 1'b1);
        cycle(0, 32'h0, 1, 0);
        chk("7f_illegal", a_illegal, 1'b1);
        drain();

        // Asynchronous reset mid-stream
        cycle(1, 32'h0000_0013, 0, 0);
        cycle(1, 32'h0000_0093, 0, 0);
        #2;
        i_rst = 1'b1;
        #1;
        q.delete();
        chk("arst_valid", a_valid, 1'b0);
        chk("arst_count", a_count, 3'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;
        check_all();

        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
